// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC register, valid-qualified imem handshake, next-PC selection.
// Optional build macro IFU_HALT_ON_ILLEGAL_EN parks the stage in HALT after an illegal instruction retires.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        arst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc_plus4,
  input  logic        branch,
  input  logic        jump,
  input  logic        alu_zero,
  output logic        illegal,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_t;

`ifdef IFU_HALT_ON_ILLEGAL_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  state_t      state_r;
  logic [31:0] br_off_s;
  logic [31:0] next_pc_s;

  function automatic logic opcode_legal(input logic [5:0] op);
    logic ok;
    case (op)
      6'h00, 6'h08, 6'h04, 6'h02, 6'h23, 6'h2B: ok = 1'b1;
      default:                                  ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Next-PC select; an illegal instruction retires as a NOP, jump outranks branch
  always_comb begin
    br_off_s  = {{14{instr[15]}}, instr[15:0], 2'b00};
    next_pc_s = pc_plus4;
    if (illegal) begin
      next_pc_s = pc_plus4;
    end else if (jump) begin
      next_pc_s = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (branch && alu_zero) begin
      next_pc_s = pc_plus4 + br_off_s;
    end else begin
      next_pc_s = pc_plus4;
    end
  end

  // Fetch/issue FSM; imem_addr doubles as the PC register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r     <= IDLE;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr       <= 32'd0;
      opcode      <= 6'd0;
      instr_valid <= 1'b0;
      pc_plus4    <= RESET_PC + 32'd4;
      illegal     <= 1'b0;
      retired     <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r  <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_valid) begin
            instr       <= imem_rdata;
            opcode      <= imem_rdata[31:26];
            pc_plus4    <= imem_addr + 32'd4;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            illegal     <= ~opcode_legal(imem_rdata[31:26]);
            state_r     <= ISSUE;
          end else begin
            imem_req <= 1'b1;
          end
        end
        ISSUE: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            retired     <= retired + 32'd1;
            if (HALT_EN && illegal) begin
              state_r <= HALT;
            end else begin
              state_r   <= FETCH;
              imem_req  <= 1'b1;
              imem_addr <= next_pc_s;
              illegal   <= 1'b0;
            end
          end else begin
            instr_valid <= 1'b1;
          end
        end
        HALT: begin
          instr_valid <= 1'b0;
          imem_req    <= 1'b0;
          illegal     <= 1'b1;
        end
        default: begin
          state_r     <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
